// File: rtl/fifo_rd_drainer_pkg.sv
// Shared types and constants for the FIFO read-side drainer.
// Also holds the skid-buffer credit helper used by the read strobe logic.
package fifo_rd_drainer_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

    // A read may be issued only if the word it returns is guaranteed a slot.
    function automatic logic has_credit(input logic [1:0] occ,
                                        input logic       inflight,
                                        input logic       pop);
        logic [2:0] pending;
        pending = 3'(occ) + 3'(inflight) - 3'(pop);
        return pending < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_rd_drainer_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the drainer.
// master = the drainer, slave = FIFO and consumer side.
interface fifo_rd_drainer_if
    import fifo_rd_drainer_pkg::*;
#(
    parameter int W = FIFO_WIDTH
) ();

    logic         fifo_rd_en;
    logic [W-1:0] fifo_dout;
    logic         fifo_empty;
    logic         fifo_underflow;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;

    modport master (
        output fifo_rd_en, m_data, m_valid,
        input  fifo_dout, fifo_empty, fifo_underflow, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_data, m_valid,
        output fifo_dout, fifo_empty, fifo_underflow, m_ready
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer absorbing the FIFO read latency.
// Head entry stays stable until popped; clear empties it without touching contents.
module fifo_rd_skid
    import fifo_rd_drainer_pkg::*;
#(
    parameter int W = FIFO_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   occ
);

    logic [W-1:0] mem_reg [SKID_DEPTH];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   occ_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else if (clear) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= din;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            occ_reg <= occ_reg + 2'(push) - 2'(pop);
        end
    end

    assign dout = mem_reg[rd_ptr_reg];
    assign occ  = occ_reg;

endmodule

// File: rtl/fifo_rd_drainer.sv
// Read-side master for the synchronous FIFO: credit-based rd_en, 1-cycle latency
// absorption into a skid buffer, and an IDLE/RUN/DRAIN control FSM.
module fifo_rd_drainer
    import fifo_rd_drainer_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flush,
    fifo_rd_drainer_if.master bus,
    output logic              busy,
    output logic              err_underflow,
    output logic [CNT_W-1:0]  rd_count
);

    rd_state_e             state_reg;
    rd_state_e             state_next;
    logic                  inflight_reg;
    logic                  err_underflow_reg;
    logic [CNT_W-1:0]      rd_count_reg;

    logic [1:0]            occ;
    logic [FIFO_WIDTH-1:0] head;
    logic                  m_valid_int;
    logic                  pop;
    logic                  push;
    logic                  clear;
    logic                  rd_en;

    assign m_valid_int = (occ != 2'd0);
    assign pop         = m_valid_int & bus.m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RD_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // flush outranks enable everywhere; DRAIN leaves only once nothing is pending
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RD_IDLE:  if (!flush && enable) state_next = RD_RUN;
            RD_RUN:   if (flush) state_next = RD_DRAIN;
                      else if (!enable) state_next = RD_IDLE;
            RD_DRAIN: if (!inflight_reg && (occ == 2'd0)) state_next = RD_IDLE;
            default:  state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        clear = 1'b0;
        case (state_reg)
            RD_IDLE:  clear = flush;
            RD_RUN:   rd_en = !bus.fifo_empty && has_credit(occ, inflight_reg, pop);
            RD_DRAIN: clear = 1'b1;
            default:  ;
        endcase
    end

    // Returned word is dropped when flagged as underflow or while the buffer is cleared
    assign push = inflight_reg & !bus.fifo_underflow & !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_reg      <= 1'b0;
            err_underflow_reg <= 1'b0;
            rd_count_reg      <= '0;
        end else begin
            inflight_reg <= rd_en;
            if (inflight_reg && bus.fifo_underflow) begin
                err_underflow_reg <= 1'b1;
            end
            if (pop) begin
                rd_count_reg <= rd_count_reg + 1'b1;
            end
        end
    end

    fifo_rd_skid #(
        .W (FIFO_WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .din   (bus.fifo_dout),
        .pop   (pop),
        .dout  (head),
        .occ   (occ)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid_int;
    assign bus.m_data     = head;

    assign busy          = (state_reg != RD_IDLE) | inflight_reg | m_valid_int;
    assign err_underflow = err_underflow_reg;
    assign rd_count      = rd_count_reg;

endmodule

// File: tb/tb_fifo_rd_drainer.sv
// Bench for fifo_rd_drainer: behavioural FIFO model, stream scoreboard, scenario tasks.
module tb_fifo_rd_drainer;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          enable = 1'b0;
    logic          flush  = 1'b0;
    logic          m_ready = 1'b0;
    logic          busy;
    logic          err_underflow;
    logic [CW-1:0] rd_count;

    fifo_rd_drainer_if #(.W(W)) bus ();

    fifo_rd_drainer #(
        .FIFO_WIDTH (W),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .flush         (flush),
        .bus           (bus),
        .busy          (busy),
        .err_underflow (err_underflow),
        .rd_count      (rd_count)
    );

    always #5 clk = ~clk;

    // FIFO model: registered data one clock after rd_en, optional forced underflow
    logic [W-1:0] fifo_mem [0:4095];
    int           head = 0;
    int           tail = 0;
    logic         force_uf = 1'b0;
    logic [W-1:0] fifo_dout_r = '0;
    logic         fifo_uf_r = 1'b0;

    assign bus.fifo_empty     = (head == tail);
    assign bus.fifo_dout      = fifo_dout_r;
    assign bus.fifo_underflow = fifo_uf_r;
    assign bus.m_ready        = m_ready;

    always @(posedge clk) begin
        fifo_uf_r <= 1'b0;
        if (bus.fifo_rd_en) begin
            if (force_uf || head == tail) begin
                fifo_uf_r <= 1'b1;
            end else begin
                fifo_dout_r <= fifo_mem[head];
                head        <= head + 1;
            end
        end
    end

    logic [W-1:0] exp_q [$];
    int n_checks  = 0;
    int n_fail    = 0;
    int delivered = 0;

    // Scoreboard: every transfer must match the oldest word still owed downstream
    always @(negedge clk) begin
        if (!rst && bus.m_valid && m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got %h, expected no transfer", bus.m_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (bus.m_data !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h, expected %h", bus.m_data, e);
                end
            end
            delivered++;
            $display("xfer %0d data=%h rd_count(pre)=%0d", delivered, bus.m_data, rd_count);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo_mem[tail] = w;
        tail = tail + 1;
        exp_q.push_back(w);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        step();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        enable  = 1'b1;
        m_ready = 1'b1;
        step();
        push_word(16'hA001);
        push_word(16'hA002);
        push_word(16'hA003);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0 || rd_count !== 4'd0 ||
                busy !== 1'b0 || err_underflow !== 1'b0 || bus.m_data !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_hold: got rd_en=%b m_valid=%b rd_count=%0d busy=%b err=%b m_data=%h, expected all 0",
                         bus.fifo_rd_en, bus.m_valid, rd_count, busy, err_underflow, bus.m_data);
            end
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_idle_rd: got %b, expected 0", bus.fifo_rd_en);
        end
        @(negedge clk);
        n_checks++;
        if (bus.fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_first_rd: got %b, expected 1", bus.fifo_rd_en);
        end
        wait_drain(50);
        n_checks++;
        if (exp_q.size() != 0 || rd_count !== 4'd3) begin
            n_fail++;
            $display("FAIL reset_drain: got left=%0d rd_count=%0d, expected left=0 rd_count=3",
                     exp_q.size(), rd_count);
        end
    endtask

    task automatic test_streaming();
        int first = -1;
        int last  = -1;
        int cnt   = 0;
        int bad   = 0;
        @(negedge clk);
        n_checks++;
        if (bus.fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_no_rd: got %b, expected 0", bus.fifo_rd_en);
        end
        step();
        for (int k = 1; k <= 8; k++) begin
            push_word(16'(k));
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.m_valid && m_ready) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
            if (bus.fifo_rd_en && bus.fifo_empty) bad++;
        end
        n_checks++;
        if (cnt != 8 || last - first != 7) begin
            n_fail++;
            $display("FAIL stream_b2b: got %0d transfers over %0d cycles, expected 8 over 8",
                     cnt, last - first + 1);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rd_while_empty: got %0d cycles, expected 0", bad);
        end
        n_checks++;
        if (rd_count !== 4'd11 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count: got rd_count=%0d left=%0d, expected 11 and 0",
                     rd_count, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        step();
        m_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            push_word(16'hB000 + 16'(k));
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus.m_valid !== 1'b1 || bus.fifo_rd_en !== 1'b0 || (tail - head) != 4) begin
            n_fail++;
            $display("FAIL bp_full: got m_valid=%b rd_en=%b fifo_left=%0d, expected 1 0 4",
                     bus.m_valid, bus.fifo_rd_en, tail - head);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.m_data !== 16'hB001 || bus.fifo_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got m_data=%h rd_en=%b, expected b001 0",
                         bus.m_data, bus.fifo_rd_en);
            end
        end
        step();
        m_ready = 1'b1;
        wait_drain(60);
        n_checks++;
        if (exp_q.size() != 0 || rd_count !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap17: got left=%0d rd_count=%0d, expected 0 and 1",
                     exp_q.size(), rd_count);
        end
    endtask

    task automatic test_flush();
        step();
        m_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push_word(16'hC000 + 16'(k));
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 16'hC001 || (tail - head) != 3) begin
            n_fail++;
            $display("FAIL flush_setup: got m_valid=%b m_data=%h fifo_left=%0d, expected 1 c001 3",
                     bus.m_valid, bus.m_data, tail - head);
        end
        step();
        flush   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_cycle_rd: got %b, expected 1", bus.fifo_rd_en);
        end
        step();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_entry: got rd_en=%b busy=%b, expected 0 1", bus.fifo_rd_en, busy);
        end
        @(negedge clk);
        n_checks++;
        if (bus.m_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear: got m_valid=%b busy=%b, expected 0 1", bus.m_valid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || (tail - head) != 2 || rd_count !== 4'd3) begin
            n_fail++;
            $display("FAIL flush_idle: got busy=%b fifo_left=%0d rd_count=%0d, expected 0 2 3",
                     busy, tail - head, rd_count);
        end
        step();
        void'(exp_q.pop_front());
        enable = 1'b1;
        wait_drain(40);
        n_checks++;
        if (exp_q.size() != 0 || rd_count !== 4'd5) begin
            n_fail++;
            $display("FAIL flush_resume: got left=%0d rd_count=%0d, expected 0 and 5",
                     exp_q.size(), rd_count);
        end
    endtask

    task automatic test_underflow();
        @(negedge clk);
        n_checks++;
        if (err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pre: got %b, expected 0", err_underflow);
        end
        step();
        force_uf = 1'b1;
        push_word(16'hD001);
        push_word(16'hD002);
        push_word(16'hD003);
        step();
        force_uf = 1'b0;
        wait_drain(40);
        n_checks++;
        if (err_underflow !== 1'b1 || exp_q.size() != 0 || rd_count !== 4'd8) begin
            n_fail++;
            $display("FAIL underflow: got err=%b left=%0d rd_count=%0d, expected 1 0 8",
                     err_underflow, exp_q.size(), rd_count);
        end
    endtask

    task automatic test_random();
        int pushed = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            enable  = ($urandom_range(0, 3) != 0);
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                push_word(16'($urandom));
                pushed++;
            end
        end
        step();
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_drain(200);
        n_checks++;
        if (exp_q.size() != 0 || rd_count !== 4'(8 + pushed)) begin
            n_fail++;
            $display("FAIL rand_drain: got left=%0d rd_count=%0d, expected 0 and %0d",
                     exp_q.size(), rd_count, 4'(8 + pushed));
        end
        n_checks++;
        if (err_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b, expected 1", err_underflow);
        end
    endtask

    task automatic test_reset_mid();
        step();
        m_ready = 1'b0;
        push_word(16'hE001);
        push_word(16'hE002);
        push_word(16'hE003);
        push_word(16'hE004);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.m_valid !== 1'b0 || rd_count !== 4'd0 || busy !== 1'b0 ||
            err_underflow !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got m_valid=%b rd_count=%0d busy=%b err=%b rd_en=%b, expected all 0",
                     bus.m_valid, rd_count, busy, err_underflow, bus.fifo_rd_en);
        end
        n_checks++;
        if ((tail - head) != 2) begin
            n_fail++;
            $display("FAIL rst_mid_reads: got fifo_left=%0d, expected 2", tail - head);
        end
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        repeat (2) step();
        rst     = 1'b0;
        m_ready = 1'b1;
        wait_drain(40);
        n_checks++;
        if (exp_q.size() != 0 || rd_count !== 4'd2) begin
            n_fail++;
            $display("FAIL rst_mid_resume: got left=%0d rd_count=%0d, expected 0 and 2",
                     exp_q.size(), rd_count);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_underflow();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
